// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared types and constants for the MIPS register-bank
//             write-back path.
//  Contents : reg_idx_t / word_t basic types, REG_ZERO, the write-back queue
//             entry layout, and the arbiter's issue-source selector.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  // Register 0 is hard-wired to zero; writes to it are discarded.
  localparam reg_idx_t REG_ZERO = 5'd0;

  // One queued multicycle result. 'kill' marks an entry superseded by a
  // younger pipeline write to the same register (field 'rd' holds the index
  // because 'reg' is a reserved word).
  typedef struct packed {
    reg_idx_t rd;
    word_t    data;
    logic     kill;
  } wbq_entry_t;

  // Which source the arbiter serves in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,  // nothing to do
    SRC_WB    = 2'd1,  // pipeline WB stage write
    SRC_QUEUE = 2'd2,  // live queue head write
    SRC_DROP  = 2'd3   // killed queue head, discarded without a bank write
  } wb_src_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : wb_queue
//  Purpose  : DEPTH-entry circular buffer holding multicycle results until
//             the bank write port is free.
//  Ports    : push_i/push_reg_i/push_data_i  - enqueue at tail
//             pop_i                          - drop head
//             head_*_o                       - head entry contents
//             kill_en_i/kill_reg_i           - mark live entries for a reg
//             chk_reg{1,2}_i / chk_hit{1,2}_o - live-entry lookup
//             full_o/empty_o/count_o         - occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module wb_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] push_reg_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          kill_en_i,
  input  logic [AW-1:0] kill_reg_i,
  input  logic [AW-1:0] chk_reg1_i,
  input  logic [AW-1:0] chk_reg2_i,
  output logic          chk_hit1_o,
  output logic          chk_hit2_o,
  output logic [AW-1:0] head_reg_o,
  output logic [DW-1:0] head_data_o,
  output logic          head_kill_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [AW-1:0] C_ZERO  = AW'(REG_ZERO);

  logic [AW-1:0]    reg_q   [DEPTH];
  logic [DW-1:0]    data_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] kill_q;
  logic [CW-1:0]    wr_ptr_q;
  logic [CW-1:0]    rd_ptr_q;

  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_rd_idx;

  assign w_wr_idx = wr_ptr_q[PW-1:0];
  assign w_rd_idx = rd_ptr_q[PW-1:0];

  // Extra pointer MSB distinguishes full (MSBs differ) from empty.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (w_wr_idx == w_rd_idx);

  assign head_reg_o  = reg_q[w_rd_idx];
  assign head_data_o = data_q[w_rd_idx];
  assign head_kill_o = kill_q[w_rd_idx];

  // Control state. Statement order matters: the kill sweep runs first, then
  // pop, then push, so an entry written this cycle always starts un-killed
  // (it is younger than the pipeline write doing the kill), and a push into
  // the slot being popped leaves that slot valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      kill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (kill_en_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && (reg_q[i] == kill_reg_i)) begin
            kill_q[i] <= 1'b1;
          end
        end
      end
      if (pop_i) begin
        valid_q[w_rd_idx] <= 1'b0;
        kill_q[w_rd_idx]  <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + CW'(1);
      end
      if (push_i) begin
        valid_q[w_wr_idx] <= 1'b1;
        kill_q[w_wr_idx]  <= 1'b0;
        wr_ptr_q          <= wr_ptr_q + CW'(1);
      end
    end
  end

  // Payload storage needs no reset: it is only observed through valid_q.
  always_ff @(posedge clk) begin
    if (push_i) begin
      reg_q[w_wr_idx]  <= push_reg_i;
      data_q[w_wr_idx] <= push_data_i;
    end
  end

  // Hazard lookup over live (valid, not killed) entries; r0 never hits.
  always_comb begin
    chk_hit1_o = 1'b0;
    chk_hit2_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !kill_q[i]) begin
        if (reg_q[i] == chk_reg1_i) chk_hit1_o = 1'b1;
        if (reg_q[i] == chk_reg2_i) chk_hit2_o = 1'b1;
      end
    end
    if (chk_reg1_i == C_ZERO) chk_hit1_o = 1'b0;
    if (chk_reg2_i == C_ZERO) chk_hit2_o = 1'b0;
  end

  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(push_i && full_o));
  a_no_pop_when_empty : assert property (@(posedge clk) disable iff (rst)
    !(pop_i && empty_o));
  a_count_in_range : assert property (@(posedge clk) disable iff (rst)
    count_o <= C_DEPTH);

endmodule : wb_queue
`default_nettype wire

// File: rtl/regbank_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_wb_arbiter
//  Purpose  : Single producer of the register bank write port. Merges the
//             in-order WB stage (fixed priority, never stalled) with
//             multicycle results (valid/ready, buffered in wb_queue).
//  Ports    : wb_valid/wb_reg/wb_data       - pipeline write request
//             mc_valid/mc_reg/mc_data/mc_ready - multicycle handshake
//             chk_reg{1,2}/chk_hit{1,2}     - decode hazard lookup
//             RegWrite/WriteReg/WriteData   - registered bank write port
//             done                          - registered "nothing outstanding"
//             pending                       - queue occupancy incl. killed
//  Revision : 1.0 - initial release
// ============================================================================
module regbank_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  input  logic          mc_valid,
  input  logic [AW-1:0] mc_reg,
  input  logic [DW-1:0] mc_data,
  output logic          mc_ready,
  input  logic [AW-1:0] chk_reg1,
  input  logic [AW-1:0] chk_reg2,
  output logic          chk_hit1,
  output logic          chk_hit2,
  output logic          RegWrite,
  output logic [AW-1:0] WriteReg,
  output logic [DW-1:0] WriteData,
  output logic          done,
  output logic [CW-1:0] pending
);

  localparam logic [AW-1:0] C_ZERO = AW'(REG_ZERO);

  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic [AW-1:0] q_head_reg;
  logic [DW-1:0] q_head_data;
  logic          q_head_kill;

  wb_src_e       src;
  logic          q_push;
  logic          q_pop;
  logic          kill_en;
  logic [CW-1:0] count_next;

  logic          RegWrite_q,  RegWrite_d;
  logic [AW-1:0] WriteReg_q,  WriteReg_d;
  logic [DW-1:0] WriteData_q, WriteData_d;
  logic          done_q,      done_d;

  // Readiness is purely a function of occupancy so the producer never sees
  // a combinational path from its own valid back to ready.
  assign mc_ready = !q_full;

  // An r0 result still completes its handshake but is not stored.
  assign q_push = mc_valid && !q_full && (mc_reg != C_ZERO);

  // Issue selection. An r0 pipeline request is not an issue, which leaves
  // the port free for the queue that cycle.
  always_comb begin
    src = SRC_NONE;
    if (wb_valid && (wb_reg != C_ZERO)) begin
      src = SRC_WB;
    end else if (!q_empty) begin
      src = q_head_kill ? SRC_DROP : SRC_QUEUE;
    end
  end

  assign q_pop   = (src == SRC_QUEUE) || (src == SRC_DROP);
  // The pipeline write is younger than anything already queued for the same
  // register, so those queued writes must never reach the bank.
  assign kill_en = (src == SRC_WB);

  wb_queue #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (q_push),
    .push_reg_i  (mc_reg),
    .push_data_i (mc_data),
    .pop_i       (q_pop),
    .kill_en_i   (kill_en),
    .kill_reg_i  (wb_reg),
    .chk_reg1_i  (chk_reg1),
    .chk_reg2_i  (chk_reg2),
    .chk_hit1_o  (chk_hit1),
    .chk_hit2_o  (chk_hit2),
    .head_reg_o  (q_head_reg),
    .head_data_o (q_head_data),
    .head_kill_o (q_head_kill),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  assign count_next = q_count + CW'(q_push) - CW'(q_pop);

  // Write port next state; index/data hold when nothing is written.
  always_comb begin
    RegWrite_d  = 1'b0;
    WriteReg_d  = WriteReg_q;
    WriteData_d = WriteData_q;
    case (src)
      SRC_WB: begin
        RegWrite_d  = 1'b1;
        WriteReg_d  = wb_reg;
        WriteData_d = wb_data;
      end
      SRC_QUEUE: begin
        RegWrite_d  = 1'b1;
        WriteReg_d  = q_head_reg;
        WriteData_d = q_head_data;
      end
      default: ;
    endcase
    done_d = (count_next == '0) && !q_push && !RegWrite_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite_q  <= 1'b0;
      WriteReg_q  <= '0;
      WriteData_q <= '0;
      done_q      <= 1'b1;
    end else begin
      RegWrite_q  <= RegWrite_d;
      WriteReg_q  <= WriteReg_d;
      WriteData_q <= WriteData_d;
      done_q      <= done_d;
    end
  end

  assign RegWrite  = RegWrite_q;
  assign WriteReg  = WriteReg_q;
  assign WriteData = WriteData_q;
  assign done      = done_q;
  assign pending   = q_count;

endmodule : regbank_wb_arbiter
`default_nettype wire

// File: tb/tb_regbank_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_wb_arbiter
//  Purpose  : Self-checking bench for regbank_wb_arbiter. A reference model
//             keeps the queue as a list of {reg, data, killed} and applies
//             the arbitration rules directly each clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid, mc_valid;
  logic [AW-1:0] wb_reg, mc_reg, chk_reg1, chk_reg2;
  logic [DW-1:0] wb_data, mc_data;
  logic          mc_ready, chk_hit1, chk_hit2, RegWrite, done;
  logic [AW-1:0] WriteReg;
  logic [DW-1:0] WriteData;
  logic [CW-1:0] pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regbank_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data), .mc_ready(mc_ready),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .done(done), .pending(pending)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    bit            killed;
  } ment_t;

  ment_t         mq[$];
  logic          exp_rw;
  logic [AW-1:0] exp_wr;
  logic [DW-1:0] exp_wd;
  logic          exp_done;

  task automatic reset_model();
    mq.delete();
    exp_rw = 1'b0; exp_wr = '0; exp_wd = '0; exp_done = 1'b1;
  endtask

  function automatic bit model_hit(logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    foreach (mq[i]) if (!mq[i].killed && mq[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [CW-1:0] model_pending();
    return CW'(mq.size());
  endfunction

  task automatic idle_inputs();
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    mc_valid = 0; mc_reg = 0; mc_data = 0;
    chk_reg1 = 0; chk_reg2 = 0;
  endtask

  // Apply the current inputs for one clock and advance the model to match.
  task automatic step();
    bit    ready, push, issued;
    ment_t e;
    ready  = (mq.size() < DEPTH);
    push   = mc_valid && ready && (mc_reg != 0);
    issued = 0;
    if (wb_valid && wb_reg != 0) begin
      foreach (mq[i]) if (mq[i].r == wb_reg) mq[i].killed = 1;
      exp_wr = wb_reg; exp_wd = wb_data; issued = 1;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (!e.killed) begin
        exp_wr = e.r; exp_wd = e.d; issued = 1;
      end
    end
    if (push) mq.push_back('{mc_reg, mc_data, 1'b0});
    exp_rw   = issued;
    exp_done = (mq.size() == 0) && !push && !issued;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
    checks++; if (WriteReg !== '0) begin failures++; $display("FAIL reset_writereg got=%0d exp=0", WriteReg); end
    checks++; if (WriteData !== '0) begin failures++; $display("FAIL reset_writedata got=%h exp=0", WriteData); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL reset_done got=%b exp=1", done); end
    checks++; if (pending !== '0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending); end
    checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL reset_mc_ready got=%b exp=1", mc_ready); end
    rst = 0;
    reset_model();
  endtask

  task automatic test_priority();
    idle_inputs();
    mc_valid = 1; mc_reg = 5; mc_data = 32'hAAAA;
    checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL prio_mc_ready got=%b exp=1", mc_ready); end
    step();
    mc_valid = 0;
    checks++; if (RegWrite !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL prio_cyc1 got rw=%b done=%b exp rw=0 done=0", RegWrite, done); end
    wb_valid = 1; wb_reg = 6; wb_data = 32'h1111;
    step();
    wb_valid = 0;
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd6 || WriteData !== 32'h1111 || done !== 1'b0) begin
      failures++; $display("FAIL prio_wb_first got rw=%b r=%0d d=%h done=%b exp rw=1 r=6 d=1111 done=0", RegWrite, WriteReg, WriteData, done); end
    step();
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'hAAAA || done !== 1'b0) begin
      failures++; $display("FAIL prio_queue_second got rw=%b r=%0d d=%h done=%b exp rw=1 r=5 d=aaaa done=0", RegWrite, WriteReg, WriteData, done); end
    step();
    checks++; if (RegWrite !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL prio_done got rw=%b done=%b exp rw=0 done=1", RegWrite, done); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] bd[5];
    logic [AW-1:0] got_r[$];
    logic [DW-1:0] got_d[$];
    bit accepted;
    idle_inputs();
    foreach (bd[i]) bd[i] = $urandom;
    wb_valid = 1; wb_reg = 7; wb_data = $urandom;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1; mc_reg = AW'(8 + i); mc_data = bd[i];
      checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_%0d got=%b exp=1", i, mc_ready); end
      step();
      checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd7) begin failures++; $display("FAIL bp_wb_hold_%0d got rw=%b r=%0d exp rw=1 r=7", i, RegWrite, WriteReg); end
    end
    mc_reg = 12; mc_data = bd[4];
    checks++; if (mc_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", mc_ready); end
    checks++; if (pending !== CW'(4)) begin failures++; $display("FAIL bp_full_pending got=%0d exp=4", pending); end
    wb_valid = 0;
    accepted = 0;
    for (int k = 0; k < 20; k++) begin
      if (!accepted && mc_valid && mc_ready) accepted = 1;
      step();
      if (accepted) mc_valid = 0;
      if (RegWrite) begin got_r.push_back(WriteReg); got_d.push_back(WriteData); end
      checks++; if (pending !== model_pending()) begin failures++; $display("FAIL bp_pending_k%0d got=%0d exp=%0d", k, pending, model_pending()); end
    end
    checks++; if (!accepted) begin failures++; $display("FAIL bp_fifth_accept got=0 exp=1"); end
    checks++; if (got_r.size() != 5) begin failures++; $display("FAIL bp_write_count got=%0d exp=5", got_r.size()); end
    for (int i = 0; i < 5 && i < got_r.size(); i++) begin
      checks++; if (got_r[i] !== AW'(8 + i) || got_d[i] !== bd[i]) begin
        failures++; $display("FAIL bp_order_%0d got r=%0d d=%h exp r=%0d d=%h", i, got_r[i], got_d[i], 8 + i, bd[i]); end
    end
  endtask

  task automatic test_waw_kill();
    idle_inputs();
    mc_valid = 1; mc_reg = 9; mc_data = 32'hDEAD;
    step();
    mc_valid = 0; chk_reg1 = 9;
    #1;
    checks++; if (chk_hit1 !== 1'b1) begin failures++; $display("FAIL waw_hit_before got=%b exp=1", chk_hit1); end
    wb_valid = 1; wb_reg = 9; wb_data = 32'hBEEF;
    step();
    wb_valid = 0;
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd9 || WriteData !== 32'hBEEF) begin
      failures++; $display("FAIL waw_wb_write got rw=%b r=%0d d=%h exp rw=1 r=9 d=beef", RegWrite, WriteReg, WriteData); end
    checks++; if (chk_hit1 !== 1'b0) begin failures++; $display("FAIL waw_hit_after got=%b exp=0", chk_hit1); end
    checks++; if (pending !== CW'(1)) begin failures++; $display("FAIL waw_pending_killed got=%0d exp=1", pending); end
    step();
    checks++; if (RegWrite !== 1'b0 || WriteData !== 32'hBEEF || pending !== '0) begin
      failures++; $display("FAIL waw_silent_pop got rw=%b d=%h pend=%0d exp rw=0 d=beef pend=0", RegWrite, WriteData, pending); end
    step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL waw_done got=%b exp=1", done); end
  endtask

  task automatic test_reg0();
    logic [AW-1:0] prev_r;
    idle_inputs();
    prev_r = exp_wr;
    wb_valid = 1; wb_reg = 0; wb_data = 32'h5;
    mc_valid = 1; mc_reg = 0; mc_data = 32'h6;
    checks++; if (mc_ready !== 1'b1) begin failures++; $display("FAIL r0_handshake got=%b exp=1", mc_ready); end
    step();
    idle_inputs();
    checks++; if (RegWrite !== 1'b0 || pending !== '0 || done !== 1'b1 || WriteReg !== prev_r) begin
      failures++; $display("FAIL r0_ignored got rw=%b pend=%0d done=%b r=%0d exp rw=0 pend=0 done=1 r=%0d", RegWrite, pending, done, WriteReg, prev_r); end
  endtask

  task automatic test_hazard();
    idle_inputs();
    wb_valid = 1; wb_reg = 20; wb_data = $urandom;
    mc_valid = 1; mc_reg = 3; mc_data = $urandom;
    step();
    mc_reg = 4; mc_data = $urandom;
    step();
    mc_valid = 0; chk_reg1 = 3; chk_reg2 = 4;
    #1;
    checks++; if (chk_hit1 !== 1'b1 || chk_hit2 !== 1'b1) begin failures++; $display("FAIL haz_both got h1=%b h2=%b exp 1 1", chk_hit1, chk_hit2); end
    chk_reg1 = 0;
    #1;
    checks++; if (chk_hit1 !== 1'b0) begin failures++; $display("FAIL haz_r0 got=%b exp=0", chk_hit1); end
    chk_reg1 = 3; wb_valid = 0;
    step();
    checks++; if (chk_hit1 !== 1'b0 || chk_hit2 !== 1'b1) begin failures++; $display("FAIL haz_after_pop got h1=%b h2=%b exp 0 1", chk_hit1, chk_hit2); end
    checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd3) begin failures++; $display("FAIL haz_pop_write got rw=%b r=%0d exp rw=1 r=3", RegWrite, WriteReg); end
    step(); step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wb_valid = ($urandom_range(0, 1) == 1);
      wb_reg   = AW'($urandom_range(0, 7));
      wb_data  = $urandom;
      mc_valid = ($urandom_range(0, 9) < 6);
      mc_reg   = AW'($urandom_range(0, 7));
      mc_data  = $urandom;
      chk_reg1 = AW'($urandom_range(0, 7));
      chk_reg2 = AW'($urandom_range(0, 7));
      #1;
      checks++; if (mc_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, mc_ready, mq.size() < DEPTH); end
      checks++; if (chk_hit1 !== model_hit(chk_reg1) || chk_hit2 !== model_hit(chk_reg2)) begin
        failures++; $display("FAIL rnd_hit n=%0d got=%b%b exp=%b%b", n, chk_hit1, chk_hit2, model_hit(chk_reg1), model_hit(chk_reg2)); end
      checks++; if (pending !== model_pending()) begin failures++; $display("FAIL rnd_pending n=%0d got=%0d exp=%0d", n, pending, model_pending()); end
      step();
      checks++; if (RegWrite !== exp_rw || WriteReg !== exp_wr || WriteData !== exp_wd || done !== exp_done) begin
        failures++; $display("FAIL rnd_port n=%0d got rw=%b r=%0d d=%h done=%b exp rw=%b r=%0d d=%h done=%b",
          n, RegWrite, WriteReg, WriteData, done, exp_rw, exp_wr, exp_wd, exp_done); end
    end
    idle_inputs();
    for (int k = 0; k < 10; k++) step();
    checks++; if (done !== 1'b1 || pending !== '0) begin failures++; $display("FAIL rnd_drain got done=%b pend=%0d exp done=1 pend=0", done, pending); end
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    wb_valid = 1; wb_reg = 1; wb_data = $urandom;
    for (int i = 0; i < 3; i++) begin
      mc_valid = 1; mc_reg = AW'(2 + i); mc_data = $urandom;
      step();
    end
    checks++; if (RegWrite !== 1'b1 || pending !== CW'(3)) begin failures++; $display("FAIL mid_setup got rw=%b pend=%0d exp rw=1 pend=3", RegWrite, pending); end
    #2;
    idle_inputs();
    rst = 1;
    #1;
    checks++; if (RegWrite !== 1'b0 || done !== 1'b1 || pending !== '0 || mc_ready !== 1'b1) begin
      failures++; $display("FAIL mid_async_reset got rw=%b done=%b pend=%0d rdy=%b exp rw=0 done=1 pend=0 rdy=1", RegWrite, done, pending, mc_ready); end
    @(posedge clk);
    #1;
    rst = 0;
    reset_model();
    step();
    checks++; if (RegWrite !== 1'b0 || done !== 1'b1 || pending !== '0) begin
      failures++; $display("FAIL mid_after_reset got rw=%b done=%b pend=%0d exp rw=0 done=1 pend=0", RegWrite, done, pending); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_backpressure();
    test_waw_kill();
    test_reg0();
    test_hazard();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_regbank_wb_arbiter
`default_nettype wire
